// File: rtl/aes_encoder.sv
// Fully pipelined AES-128 encryption core: one block per clock, ten round stages,
// each stage carrying its own state, round key and valid bit.
module aes_encoder #(
    parameter int KEY_SIZE  = 128,
    parameter int KEY_BYTES = KEY_SIZE / 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [0:15][7:0]          plainData,
    input  logic [0:KEY_BYTES-1][7:0] key,
    output logic [0:15][7:0]          encryptData,
    output logic                      valid
);

    localparam int NUM_ROUNDS = KEY_SIZE / 32 + 6;

    if (KEY_SIZE != 128) begin : g_bad_key_size
        $error("aes_encoder supports only KEY_SIZE = 128");
    end

    typedef logic [7:0]       byte_t;
    typedef logic [0:15][7:0] state_t;

    localparam byte_t RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    function automatic byte_t xtime(input byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t acc;
        byte_t p;
        acc = '0;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // S-box as multiplicative inverse (a^254, zero maps to zero) followed by the affine map.
    function automatic byte_t sub_byte(input byte_t a);
        byte_t sq;
        byte_t inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic state_t sub_bytes(input state_t s);
        state_t o;
        for (int i = 0; i < 16; i++) o[i] = sub_byte(s[i]);
        return o;
    endfunction

    function automatic state_t shift_rows(input state_t s);
        state_t o;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) o[r + 4*c] = s[r + 4*((c + r) % 4)];
        end
        return o;
    endfunction

    function automatic state_t mix_columns(input state_t s);
        state_t o;
        byte_t  a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[4*c];
            a1 = s[4*c + 1];
            a2 = s[4*c + 2];
            a3 = s[4*c + 3];
            o[4*c]     = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[4*c + 1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[4*c + 2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[4*c + 3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    // Next round key: word 0 absorbs SubWord(RotWord(w3)) ^ Rcon, later words chain forward.
    function automatic state_t key_expand(input state_t k, input byte_t rcon);
        state_t           nk;
        logic [0:3][7:0]  t;
        t[0] = sub_byte(k[13]) ^ rcon;
        t[1] = sub_byte(k[14]);
        t[2] = sub_byte(k[15]);
        t[3] = sub_byte(k[12]);
        for (int b = 0; b < 4; b++)         nk[b] = k[b] ^ t[b];
        for (int b = 4; b < KEY_BYTES; b++) nk[b] = k[b] ^ nk[b - 4];
        return nk;
    endfunction

    function automatic state_t aes_round(input state_t s, input state_t rk, input logic last);
        state_t t;
        t = shift_rows(sub_bytes(s));
        if (!last) t = mix_columns(t);
        return t ^ rk;
    endfunction

    state_t                r_state [1:NUM_ROUNDS];
    state_t                r_key   [1:NUM_ROUNDS];
    logic [NUM_ROUNDS:1]   r_valid;

    state_t                w_state_d [1:NUM_ROUNDS];
    state_t                w_key_d   [1:NUM_ROUNDS];

    // NOTE: every array element is assigned on every pass, so no latch can be inferred.
    // Empty stages propagate zeros so encryptData stays 0 whenever valid is 0.
    always_comb begin
        w_key_d[1]   = key_expand(key, RCON[1]);
        w_state_d[1] = aes_round(plainData ^ key, w_key_d[1], 1'b0);
        for (int i = 2; i <= NUM_ROUNDS; i++) begin
            w_key_d[i]   = r_valid[i-1] ? key_expand(r_key[i-1], RCON[i]) : '0;
            w_state_d[i] = r_valid[i-1]
                         ? aes_round(r_state[i-1], w_key_d[i], i == NUM_ROUNDS) : '0;
        end
    end

    // NOTE: pipeline state uses non-blocking assignments so all stages shift on the same edge.
    // NOTE: these are pipeline registers, not a RAM, so every stage is cleared on reset
    // and no in-flight block can surface afterwards.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 1; i <= NUM_ROUNDS; i++) begin
                r_state[i] <= '0;
                r_key[i]   <= '0;
            end
            r_valid <= '0;
        end else begin
            for (int i = 1; i <= NUM_ROUNDS; i++) begin
                r_state[i] <= w_state_d[i];
                r_key[i]   <= w_key_d[i];
            end
            r_valid <= {r_valid[NUM_ROUNDS-1:1], 1'b1};
        end
    end

    assign encryptData = r_state[NUM_ROUNDS];
    assign valid       = r_valid[NUM_ROUNDS];

endmodule

// File: tb/tb_aes_encoder.sv
// Self-checking bench for aes_encoder: FIPS-197 known answers, random streaming blocks
// and mid-stream resets, scored against a matrix-form AES reference model.
module tb_aes_encoder;

    localparam int LAT = 9;  // edges between sampling a block and seeing it after an edge

    logic         clock;
    logic         reset;
    logic [127:0] plainData;
    logic [127:0] key;
    logic [127:0] encryptData;
    logic         valid;

    int total = 0;
    int bad   = 0;

    logic [7:0]   sbox_tbl [256];
    logic [127:0] exp_h [$];
    bit           rst_h [$];
    logic [127:0] kat_ct  [int];
    string        kat_tag [int];

    aes_encoder dut (
        .clock       (clock),
        .reset       (reset),
        .plainData   (plainData),
        .key         (key),
        .encryptData (encryptData),
        .valid       (valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        int p;
        int x;
        p = 0;
        x = int'(a);
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x << 1;
            if ((x & 'h100) != 0) x = x ^ 'h11b;
        end
        return p[7:0];
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] a);
        logic [7:0] c;
        logic [7:0] b;
        c = 8'h63;
        for (int i = 0; i < 8; i++)
            b[i] = a[i] ^ a[(i+4)%8] ^ a[(i+5)%8] ^ a[(i+6)%8] ^ a[(i+7)%8] ^ c[i];
        return b;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
            sbox_tbl[x] = affine(inv);
        end
    endtask

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] k);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   st [4][4];
        logic [7:0]   tmp [4][4];
        logic [7:0]   a [4];
        logic [127:0] out;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tbl[t[31:24]], sbox_tbl[t[23:16]], sbox_tbl[t[15:8]], sbox_tbl[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                st[r][c] = pt[127-8*(r+4*c) -: 8] ^ w[c][31-8*r -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) tmp[r][c] = sbox_tbl[st[r][(c+r)%4]];
            st = tmp;
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) a[r] = st[r][c];
                    for (int r = 0; r < 4; r++)
                        st[r][c] = gmul(8'h02, a[r]) ^ gmul(8'h03, a[(r+1)%4])
                                 ^ a[(r+2)%4] ^ a[(r+3)%4];
                end
            end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) st[r][c] = st[r][c] ^ w[4*rnd+c][31-8*r -: 8];
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) out[127-8*(r+4*c) -: 8] = st[r][c];
        return out;
    endfunction

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Output after edge n is the block sampled at edge n-LAT, unless a reset edge hit that window.
    task automatic score(input int n);
        int           m;
        bit           ev;
        logic [127:0] ed;
        m  = n - LAT;
        ev = (m >= 0);
        if (ev) for (int j = m; j <= n; j++) if (rst_h[j]) ev = 1'b0;
        ed = '0;
        if (ev) ed = exp_h[m];
        check($sformatf("valid@%0d", n), {127'b0, valid}, {127'b0, ev});
        check($sformatf("data@%0d", n), encryptData, ed);
        if (kat_ct.exists(n)) check(kat_tag[n], encryptData, kat_ct[n]);
    endtask

    task automatic tick(input bit rst, input logic [127:0] pt, input logic [127:0] k);
        int n;
        reset     = rst;
        plainData = pt;
        key       = k;
        @(posedge clock);
        n = exp_h.size();
        exp_h.push_back(ref_encrypt(pt, k));
        rst_h.push_back(rst);
        @(negedge clock);
        score(n);
    endtask

    task automatic drive_kat(input string tag, input logic [127:0] pt,
                             input logic [127:0] k, input logic [127:0] ct);
        kat_ct[exp_h.size() + LAT]  = ct;
        kat_tag[exp_h.size() + LAT] = tag;
        tick(1'b0, pt, k);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        reset     = 1'b1;
        plainData = '0;
        key       = '0;
        build_sbox();

        tick(1'b1, '0, '0);

        drive_kat("kat_fips_b", 128'h3243f6a8885a308d313198a2e0370734,
                  128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32);
        drive_kat("kat_fips_c1", 128'h00112233445566778899aabbccddeeff,
                  128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        drive_kat("kat_zero", '0, '0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
        for (int i = 0; i < 12; i++) tick(1'b0, rand128(), rand128());

        tick(1'b1, rand128(), rand128());
        tick(1'b1, rand128(), rand128());
        for (int i = 0; i < 5; i++) tick(1'b0, rand128(), rand128());
        tick(1'b1, rand128(), rand128());
        drive_kat("kat_after_reset", 128'h00112233445566778899aabbccddeeff,
                  128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        for (int i = 0; i < 12; i++) tick(1'b0, rand128(), rand128());

        drive_kat("kat_zero_late", '0, '0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
        for (int i = 0; i < 10; i++) tick(1'b0, rand128(), rand128());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
